// File: rtl/multiplier_if.sv
// Operand/result handshake bundle for the shift-and-add multiply-accumulate unit.
// Signal names are given from the unit's side: _i flows into it, _o flows out of it.
interface multiplier_if #(
  parameter int unsigned NBITS = 8
);
  logic               wr_valid_i;
  logic [NBITS-1:0]   wr_multiplicand_i;
  logic [NBITS-1:0]   wr_multiplier_i;
  logic [NBITS-1:0]   wr_addend_i;
  logic               wr_ready_o;
  logic               rd_valid_o;
  logic [2*NBITS-1:0] rd_product_o;
  logic               rd_ready_i;

  // The multiply unit itself.
  modport slave (
    input  wr_valid_i, wr_multiplicand_i, wr_multiplier_i, wr_addend_i, rd_ready_i,
    output wr_ready_o, rd_valid_o, rd_product_o
  );

  // Producer of operands and consumer of results.
  modport master (
    output wr_valid_i, wr_multiplicand_i, wr_multiplier_i, wr_addend_i, rd_ready_i,
    input  wr_ready_o, rd_valid_o, rd_product_o
  );
endinterface

// File: rtl/multiplier.sv
// Sequential shift-and-add multiply-accumulate: P = A*B + C, one multiplier bit per clock.
// Optional MULTIPLIER_EARLY_EXIT_EN ends the iteration as soon as the remaining multiplier is zero.
module multiplier #(
  parameter int unsigned NBITS = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  multiplier_if.slave  bus
);

  localparam int unsigned PW = 2 * NBITS;
  localparam int unsigned CW = $clog2(NBITS + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_SEND = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   mcand_q, mcand_d;
  logic [NBITS-1:0] mult_q, mult_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            wr_ready_q, wr_ready_d;
  logic            rd_valid_q, rd_valid_d;
  logic [PW-1:0]   rd_product_q, rd_product_d;
  logic            calc_done_c;

  // Iteration finishes when all bits are consumed (or, with early exit, nothing is left to add).
`ifdef MULTIPLIER_EARLY_EXIT_EN
  assign calc_done_c = (cnt_q == '0) || (mult_q == '0);
`else
  assign calc_done_c = (cnt_q == '0);
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      mcand_q      <= '0;
      mult_q       <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      wr_ready_q   <= 1'b1;
      rd_valid_q   <= 1'b0;
      rd_product_q <= '0;
    end else begin
      state_q      <= state_d;
      mcand_q      <= mcand_d;
      mult_q       <= mult_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      wr_ready_q   <= wr_ready_d;
      rd_valid_q   <= rd_valid_d;
      rd_product_q <= rd_product_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    mcand_d      = mcand_q;
    mult_d       = mult_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    wr_ready_d   = wr_ready_q;
    rd_valid_d   = rd_valid_q;
    rd_product_d = rd_product_q;

    case (state_q)
      S_IDLE: begin
        wr_ready_d = 1'b1;
        rd_valid_d = 1'b0;
        // Operands are captured only here; upstream may change them afterwards.
        if (bus.wr_valid_i && wr_ready_q) begin
          mcand_d    = PW'(bus.wr_multiplicand_i);
          mult_d     = bus.wr_multiplier_i;
          acc_d      = PW'(bus.wr_addend_i);
          cnt_d      = CW'(NBITS);
          wr_ready_d = 1'b0;
          state_d    = S_CALC;
        end
      end

      S_CALC: begin
        if (calc_done_c) begin
          rd_product_d = acc_q;
          rd_valid_d   = 1'b1;
          state_d      = S_SEND;
        end else begin
          if (mult_q[0]) begin
            acc_d = acc_q + mcand_q;
          end
          mcand_d = mcand_q << 1;
          mult_d  = mult_q >> 1;
          cnt_d   = cnt_q - CW'(1);
        end
      end

      S_SEND: begin
        if (bus.rd_ready_i) begin
          rd_valid_d = 1'b0;
          wr_ready_d = 1'b1;
          state_d    = S_IDLE;
        end
      end

      default: begin
        wr_ready_d = 1'b1;
        rd_valid_d = 1'b0;
        state_d    = S_IDLE;
      end
    endcase
  end

  assign bus.wr_ready_o   = wr_ready_q;
  assign bus.rd_valid_o   = rd_valid_q;
  assign bus.rd_product_o = rd_product_q;

endmodule

// File: tb/tb_multiplier.sv
// Directed self-checking bench for the multiply-accumulate unit (NBITS=8).
// Expected latencies follow MULTIPLIER_EARLY_EXIT_EN when it is defined.
module tb_multiplier;

  localparam int unsigned NB = 8;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  multiplier_if #(.NBITS(NB)) bus ();

  multiplier #(.NBITS(NB)) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int exp_lat(input logic [NB-1:0] b);
    int l;
`ifdef MULTIPLIER_EARLY_EXIT_EN
    l = 1;
    for (int i = 0; i < int'(NB); i++) begin
      if (b[i]) l = i + 2;
    end
`else
    l = b[0] ? int'(NB) + 1 : int'(NB) + 1;
`endif
    return l;
  endfunction

  // Issue one operation from a negedge; returns result, edges-to-valid, hold stability, timeout.
  task automatic run_op(input logic [NB-1:0] a, input logic [NB-1:0] b, input logic [NB-1:0] c,
                        input int stall, output logic [2*NB-1:0] prod, output int lat,
                        output bit held, output bit tmo);
    bus.wr_multiplicand_i = a;
    bus.wr_multiplier_i   = b;
    bus.wr_addend_i       = c;
    bus.wr_valid_i        = 1'b1;
    bus.rd_ready_i        = (stall == 0);
    @(posedge clk);
    @(negedge clk);
    bus.wr_valid_i        = 1'b0;
    bus.wr_multiplicand_i = NB'($urandom);
    bus.wr_multiplier_i   = NB'($urandom);
    bus.wr_addend_i       = NB'($urandom);
    lat  = 0;
    tmo  = 1'b1;
    held = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.rd_valid_o === 1'b1) begin
        lat = k;
        tmo = 1'b0;
        break;
      end
    end
    prod = bus.rd_product_o;
    if (!tmo) begin
      repeat (stall) begin
        @(posedge clk);
        @(negedge clk);
        if (bus.rd_valid_o !== 1'b1 || bus.rd_product_o !== prod) held = 1'b0;
      end
      bus.rd_ready_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.rd_ready_i = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    n_cmp++; if (bus.wr_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_wr_ready got=%b exp=1", bus.wr_ready_o); end
    n_cmp++; if (bus.rd_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid got=%b exp=0", bus.rd_valid_o); end
    n_cmp++; if (bus.rd_product_o !== 16'd0) begin n_err++; $display("FAIL reset_product got=%0d exp=0", bus.rd_product_o); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [2*NB-1:0] p; int lat; bit held; bit tmo;
    run_op(8'd200, 8'd150, 8'd77, 0, p, lat, held, tmo);
    n_cmp++; if (tmo) begin n_err++; $display("FAIL basic_timeout got=no_valid exp=valid"); end
    n_cmp++; if (p !== 16'h757D) begin n_err++; $display("FAIL basic_product got=%0d exp=30077", p); end
    n_cmp++; if (lat != exp_lat(8'd150)) begin n_err++; $display("FAIL basic_latency got=%0d exp=%0d", lat, exp_lat(8'd150)); end
    n_cmp++; if (bus.rd_valid_o !== 1'b0) begin n_err++; $display("FAIL basic_valid_one_cycle got=%b exp=0", bus.rd_valid_o); end
    n_cmp++; if (bus.wr_ready_o !== 1'b1) begin n_err++; $display("FAIL basic_wr_ready_back got=%b exp=1", bus.wr_ready_o); end
  endtask

  task automatic test_extremes();
    logic [2*NB-1:0] p; int lat; bit held; bit tmo;
    run_op(8'd255, 8'd255, 8'd255, 0, p, lat, held, tmo);
    n_cmp++; if (tmo || p !== 16'hFF00) begin n_err++; $display("FAIL max_product got=%0d tmo=%0d exp=65280", p, tmo); end
    run_op(8'd0, 8'd0, 8'd0, 0, p, lat, held, tmo);
    n_cmp++; if (tmo || p !== 16'd0) begin n_err++; $display("FAIL zero_product got=%0d tmo=%0d exp=0", p, tmo); end
    n_cmp++; if (lat != exp_lat(8'd0)) begin n_err++; $display("FAIL zero_latency got=%0d exp=%0d", lat, exp_lat(8'd0)); end
  endtask

  task automatic test_divider_roundtrip();
    bit seen;
    bus.wr_multiplicand_i = 8'd13;
    bus.wr_multiplier_i   = 8'd7;
    bus.wr_addend_i       = 8'd5;
    bus.wr_valid_i        = 1'b1;
    bus.rd_ready_i        = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.wr_valid_i = 1'b0;
    seen = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.rd_valid_o === 1'b1) begin seen = 1'b1; break; end
    end
    n_cmp++; if (!seen) begin n_err++; $display("FAIL rt_timeout got=no_valid exp=valid"); end
    // Upstream tries to push a new operand set while the result is stalled.
    bus.wr_multiplicand_i = 8'd9;
    bus.wr_multiplier_i   = 8'd9;
    bus.wr_addend_i       = 8'd9;
    bus.wr_valid_i        = 1'b1;
    for (int s = 0; s < 5; s++) begin
      n_cmp++; if (bus.wr_ready_o !== 1'b0) begin n_err++; $display("FAIL rt_wr_ready_stall%0d got=%b exp=0", s, bus.wr_ready_o); end
      n_cmp++; if (bus.rd_valid_o !== 1'b1 || bus.rd_product_o !== 16'd96) begin
        n_err++; $display("FAIL rt_hold%0d got=v%b/%0d exp=v1/96", s, bus.rd_valid_o, bus.rd_product_o); end
      @(posedge clk);
      @(negedge clk);
    end
    bus.wr_valid_i = 1'b0;
    bus.rd_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rd_ready_i = 1'b0;
    n_cmp++; if (bus.rd_valid_o !== 1'b0 || bus.wr_ready_o !== 1'b1) begin
      n_err++; $display("FAIL rt_release got=v%b/r%b exp=v0/r1", bus.rd_valid_o, bus.wr_ready_o); end
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.rd_valid_o !== 1'b0 || bus.wr_ready_o !== 1'b1) seen = 1'b1;
    end
    n_cmp++; if (seen) begin n_err++; $display("FAIL rt_no_ghost_op got=activity exp=idle"); end
  endtask

  task automatic test_async_reset();
    logic [2*NB-1:0] p; int lat; bit held; bit tmo;
    bus.wr_multiplicand_i = 8'd50;
    bus.wr_multiplier_i   = 8'd200;
    bus.wr_addend_i       = 8'd9;
    bus.wr_valid_i        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.wr_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    n_cmp++; if (bus.wr_ready_o !== 1'b0) begin n_err++; $display("FAIL ar_busy got=%b exp=0", bus.wr_ready_o); end
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.wr_ready_o !== 1'b1) begin n_err++; $display("FAIL ar_wr_ready got=%b exp=1", bus.wr_ready_o); end
    n_cmp++; if (bus.rd_valid_o !== 1'b0) begin n_err++; $display("FAIL ar_rd_valid got=%b exp=0", bus.rd_valid_o); end
    n_cmp++; if (bus.rd_product_o !== 16'd0) begin n_err++; $display("FAIL ar_product got=%0d exp=0", bus.rd_product_o); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op(8'd3, 8'd4, 8'd1, 0, p, lat, held, tmo);
    n_cmp++; if (tmo || p !== 16'd13) begin n_err++; $display("FAIL ar_after_product got=%0d tmo=%0d exp=13", p, tmo); end
  endtask

  task automatic test_early_exit();
    logic [2*NB-1:0] p; int lat; bit held; bit tmo;
    run_op(8'd99, 8'd0, 8'd12, 0, p, lat, held, tmo);
    n_cmp++; if (tmo || p !== 16'd12) begin n_err++; $display("FAIL ee_b0_product got=%0d tmo=%0d exp=12", p, tmo); end
`ifdef MULTIPLIER_EARLY_EXIT_EN
    n_cmp++; if (lat != 1) begin n_err++; $display("FAIL ee_b0_latency got=%0d exp=1", lat); end
`else
    n_cmp++; if (lat != 9) begin n_err++; $display("FAIL ee_b0_latency got=%0d exp=9", lat); end
`endif
    run_op(8'd5, 8'd1, 8'd0, 0, p, lat, held, tmo);
    n_cmp++; if (tmo || p !== 16'd5) begin n_err++; $display("FAIL ee_b1_product got=%0d tmo=%0d exp=5", p, tmo); end
`ifdef MULTIPLIER_EARLY_EXIT_EN
    n_cmp++; if (lat != 2) begin n_err++; $display("FAIL ee_b1_latency got=%0d exp=2", lat); end
`else
    n_cmp++; if (lat != 9) begin n_err++; $display("FAIL ee_b1_latency got=%0d exp=9", lat); end
`endif
  endtask

  task automatic test_back_to_back();
    logic [2*NB-1:0] p; logic [2*NB-1:0] e; int lat; bit held; bit tmo;
    logic [NB-1:0] a, b, c; int stall;
    for (int i = 0; i < 10; i++) begin
      a = NB'($urandom);
      b = NB'($urandom);
      c = NB'($urandom);
      stall = int'($urandom_range(0, 4));
      e = (2*NB)'(a) * (2*NB)'(b) + (2*NB)'(c);
      run_op(a, b, c, stall, p, lat, held, tmo);
      n_cmp++; if (tmo || p !== e) begin
        n_err++; $display("FAIL b2b%0d_product a=%0d b=%0d c=%0d got=%0d tmo=%0d exp=%0d", i, a, b, c, p, tmo, e); end
      n_cmp++; if (lat != exp_lat(b)) begin n_err++; $display("FAIL b2b%0d_latency got=%0d exp=%0d", i, lat, exp_lat(b)); end
      n_cmp++; if (!held) begin n_err++; $display("FAIL b2b%0d_hold got=unstable exp=stable stall=%0d", i, stall); end
      n_cmp++; if (bus.rd_valid_o !== 1'b0 || bus.wr_ready_o !== 1'b1) begin
        n_err++; $display("FAIL b2b%0d_handoff got=v%b/r%b exp=v0/r1", i, bus.rd_valid_o, bus.wr_ready_o); end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    bus.wr_valid_i        = 1'b0;
    bus.wr_multiplicand_i = '0;
    bus.wr_multiplier_i   = '0;
    bus.wr_addend_i       = '0;
    bus.rd_ready_i        = 1'b0;
    test_reset();
    test_basic();
    test_extremes();
    test_divider_roundtrip();
    test_async_reset();
    test_early_exit();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
